// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule streaming round keys 0..10 over valid/ready
module s_box (
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ a : p;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] p, r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    logic [7:0] w_b;
    assign w_b = ginv(i_a);
    assign o_s = w_b ^ {w_b[6:0], w_b[7]} ^ {w_b[5:0], w_b[7:6]} ^ {w_b[4:0], w_b[7:5]}
               ^ {w_b[3:0], w_b[7:4]} ^ 8'h63;
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_round,
    output logic [127:0] round_key,
    output logic         done
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] EXPAND = 1'b1;

    logic [0:0]   r_state;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;
    logic         r_done;
    logic [31:0]  w_rot, w_sub, w_t, w_n0, w_n1, w_n2, w_n3;
    logic [7:0]   w_xt;

    assign w_rot = {r_key[23:0], r_key[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sb
        s_box u_sb (.i_a(w_rot[8*i +: 8]), .o_s(w_sub[8*i +: 8]));
    end

    assign w_t  = w_sub ^ {r_rcon, 24'h0};
    assign w_n0 = r_key[127:96] ^ w_t;
    assign w_n1 = r_key[95:64] ^ w_n0;
    assign w_n2 = r_key[63:32] ^ w_n1;
    assign w_n3 = r_key[31:0] ^ w_n2;
    assign w_xt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    assign busy      = r_state == EXPAND;
    assign rk_valid  = r_state == EXPAND;
    assign rk_round  = r_round;
    assign round_key = r_key;
    assign done      = r_done;

    // load on start, advance one round per transfer, leave after the round-10 transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_key   <= 128'h0;
            r_round <= 4'd0;
            r_rcon  <= 8'h01;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_state <= EXPAND;
                    r_key   <= key_in;
                    r_round <= 4'd0;
                    r_rcon  <= 8'h01;
                end
            end else if (rk_ready) begin
                if (r_round == 4'd10) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end else begin
                    r_key   <= {w_n0, w_n1, w_n2, w_n3};
                    r_round <= r_round + 4'd1;
                    r_rcon  <= w_xt;
                end
            end
        end
    end
endmodule
